dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory. It shares the memory between the core load/store port and a DMA/debug port, drives the memory's read/write select, address and write data, and returns registered read data to whichever port was granted. It sits between the core datapath, the DMA engine and the data memory instance. It supports DMA bus locking for bursts and a compile-time anti-starvation counter.

---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: core vs DMA,
// with DMA bus locking. Optional anti-starvation counter under `DMEM_ARB_STARVE_EN.
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRESS  = 10,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [ADDRESS-1:0] c_addr,
  input  logic [WIDTH-1:0]   c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [WIDTH-1:0]   c_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDRESS-1:0] d_addr,
  input  logic [WIDTH-1:0]   d_wdata,
  input  logic               d_lock,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               mem_rw,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata
);

  typedef enum logic [0:0] {FREE = 1'b0, DMA_LOCKED = 1'b1} owner_e;

  owner_e             state_r;
  owner_e             state_nxt_s;
  logic               c_gnt_s;
  logic               d_gnt_s;
  logic               force_dma_s;
  logic               mem_rw_s;
  logic [ADDRESS-1:0] mem_addr_s;
  logic [WIDTH-1:0]   mem_wdata_s;
  logic               c_rvalid_r;
  logic               d_rvalid_r;
  logic [WIDTH-1:0]   c_rdata_r;
  logic [WIDTH-1:0]   d_rdata_r;

  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_max_wait_bad
    $error("dmem_arbiter: MAX_WAIT must be in 1..255");
  end

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] wait_cnt_r;

  // Count cycles a pending DMA request is refused; any grant or idle cycle restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (d_gnt_s || !d_req) begin
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  assign force_dma_s = d_req && (wait_cnt_r == 8'(MAX_WAIT));
`else
  assign force_dma_s = 1'b0;
`endif

  // Owner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Owner next-state: a locked DMA grant takes the memory, an unlocked grant or idle DMA frees it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FREE: begin
        if (d_gnt_s && d_lock) begin
          state_nxt_s = DMA_LOCKED;
        end else begin
          state_nxt_s = FREE;
        end
      end
      DMA_LOCKED: begin
        if (!d_req || (d_gnt_s && !d_lock)) begin
          state_nxt_s = FREE;
        end else begin
          state_nxt_s = DMA_LOCKED;
        end
      end
      default: state_nxt_s = FREE;
    endcase
  end

  // Grant decode: core priority in FREE unless the DMA is being forced through.
  always_comb begin
    c_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (reset) begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else begin
      case (state_r)
        FREE: begin
          if (c_req && !force_dma_s) begin
            c_gnt_s = 1'b1;
          end else if (d_req) begin
            d_gnt_s = 1'b1;
          end else begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
          end
        end
        DMA_LOCKED: d_gnt_s = d_req;
        default: begin
          c_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Memory drive mux; bus is parked at zero with no grant so no stray write can occur.
  always_comb begin
    mem_rw_s    = 1'b0;
    mem_addr_s  = {ADDRESS{1'b0}};
    mem_wdata_s = {WIDTH{1'b0}};
    if (c_gnt_s) begin
      mem_rw_s    = c_we;
      mem_addr_s  = c_addr;
      mem_wdata_s = c_wdata;
    end else if (d_gnt_s) begin
      mem_rw_s    = d_we;
      mem_addr_s  = d_addr;
      mem_wdata_s = d_wdata;
    end else begin
      mem_rw_s    = 1'b0;
      mem_addr_s  = {ADDRESS{1'b0}};
      mem_wdata_s = {WIDTH{1'b0}};
    end
  end

  // Read return: capture memory data for the granted read port, one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      c_rdata_r  <= {WIDTH{1'b0}};
      d_rdata_r  <= {WIDTH{1'b0}};
    end else begin
      c_rvalid_r <= c_gnt_s && !c_we;
      d_rvalid_r <= d_gnt_s && !d_we;
      if (c_gnt_s && !c_we) begin
        c_rdata_r <= mem_rdata;
      end
      if (d_gnt_s && !d_we) begin
        d_rdata_r <= mem_rdata;
      end
    end
  end

  assign c_gnt     = c_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign mem_rw    = mem_rw_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign c_rvalid  = c_rvalid_r;
  assign d_rvalid  = d_rvalid_r;
  assign c_rdata   = c_rdata_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, corner-case sequences and a randomized
// run against a rule-level reference model. Expectations follow `DMEM_ARB_STARVE_EN.
`timescale 1ns/1ps

module tb_dmem_arbiter;
  localparam int WIDTH    = 32;
  localparam int ADDRESS  = 10;
  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [9:0]  c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        cg;
    logic        dg;
    logic        mrw;
    logic [9:0]  maddr;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic c_req, c_we, c_gnt, c_rvalid;
  logic [ADDRESS-1:0] c_addr;
  logic [WIDTH-1:0] c_wdata, c_rdata;
  logic d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [ADDRESS-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata, d_rdata;
  logic mem_rw;
  logic [ADDRESS-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  logic [WIDTH-1:0] mem     [0:(1<<ADDRESS)-1];
  logic [WIDTH-1:0] ref_mem [0:(1<<ADDRESS)-1];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.WIDTH(WIDTH), .ADDRESS(ADDRESS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the edge closing the grant cycle.
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input bit rst, input bit cr, input bit cw, input int ca,
                             input logic [31:0] cd, input bit dr, input bit dw, input int da,
                             input logic [31:0] dd, input bit dl);
    in_t v;
    v.rst = rst; v.c_req = cr; v.c_we = cw; v.c_addr = 10'(ca); v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = 10'(da); v.d_wdata = dd; v.d_lock = dl;
    return v;
  endfunction

  function automatic vec_t vx(input in_t i, input bit cg, input bit dg, input bit mrw,
                              input int maddr, input bit crv, input logic [31:0] crd,
                              input bit drv, input logic [31:0] drd);
    vec_t v;
    v.in = i; v.cg = cg; v.dg = dg; v.mrw = mrw; v.maddr = 10'(maddr);
    v.crv = crv; v.crd = crd; v.drv = drv; v.drd = drd;
    return v;
  endfunction

  task automatic apply(input in_t v);
    reset = v.rst; c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_lock = v.d_lock;
  endtask

  // One cycle: drive just after the rising edge, then wait to the falling edge to sample.
  task automatic cyc(input in_t v);
    @(posedge clk);
    #1;
    apply(v);
    @(negedge clk);
  endtask

  vec_t tbl [12];
  in_t  idle;

  // Reference model state (random phase)
  bit          m_locked;
  int          m_wait;
  bit          m_crv, m_drv;
  logic [31:0] m_crd, m_drd;

  initial begin
    in_t v;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < (1 << ADDRESS); i++) mem[i] = 32'hA5A50000 ^ (32'(i) * 32'h01010101);
    mem[5] = 32'hDEADBEEF;

    tbl[0]  = vx(mk(1, 1, 0, 7, 0, 1, 0, 9, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = vx(mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0), 1, 0, 0, 5, 0, 0, 0, 0);
    tbl[2]  = vx(idle, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    tbl[3]  = vx(idle, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = vx(mk(0, 1, 1, 3, 32'h12345678, 0, 0, 0, 0, 0), 1, 0, 1, 3, 0, 32'hDEADBEEF, 0, 0);
    tbl[5]  = vx(mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 0), 0, 1, 0, 3, 0, 32'hDEADBEEF, 0, 0);
    tbl[6]  = vx(idle, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'h12345678);
    tbl[7]  = vx(mk(0, 1, 0, 3, 0, 1, 1, 4, 32'h55, 0), 1, 0, 0, 3, 0, 32'hDEADBEEF, 0, 32'h12345678);
    tbl[8]  = vx(idle, 0, 0, 0, 0, 1, 32'h12345678, 0, 32'h12345678);
    tbl[9]  = vx(mk(0, 0, 0, 0, 0, 1, 1, 6, 32'hCAFE0001, 0), 0, 1, 1, 6, 0, 32'h12345678, 0, 32'h12345678);
    tbl[10] = vx(mk(0, 1, 0, 6, 0, 0, 0, 0, 0, 0), 1, 0, 0, 6, 0, 32'h12345678, 0, 32'h12345678);
    tbl[11] = vx(idle, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 32'h12345678);

    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("vec%0d c_gnt", i), 32'(c_gnt), 32'(tbl[i].cg));
      chk($sformatf("vec%0d d_gnt", i), 32'(d_gnt), 32'(tbl[i].dg));
      chk($sformatf("vec%0d mem_rw", i), 32'(mem_rw), 32'(tbl[i].mrw));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("vec%0d c_rvalid", i), 32'(c_rvalid), 32'(tbl[i].crv));
      chk($sformatf("vec%0d c_rdata", i), c_rdata, tbl[i].crd);
      chk($sformatf("vec%0d d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].drv));
      chk($sformatf("vec%0d d_rdata", i), d_rdata, tbl[i].drd);
    end

    // Both ports hammering: strict core priority, or one forced DMA grant after MAX_WAIT refusals.
    for (int i = 0; i < 17; i++) begin
      cyc(mk(0, 1, 0, 1, 0, 1, 0, 2, 0, 0));
      chk($sformatf("starve%0d c_gnt", i), 32'(c_gnt), 32'(!(STARVE_EN && i == MAX_WAIT)));
      chk($sformatf("starve%0d d_gnt", i), 32'(d_gnt), 32'(STARVE_EN && i == MAX_WAIT));
    end
    cyc(idle);

    // Locked DMA write burst keeps the core out until the unlocked last beat.
    for (int i = 0; i < 4; i++) begin
      cyc(mk(0, i > 0, 0, 1, 0, 1, 1, 100 + i, 32'hB0000000 + 32'(i), i < 3));
      chk($sformatf("burst%0d c_gnt", i), 32'(c_gnt), 32'd0);
      chk($sformatf("burst%0d d_gnt", i), 32'(d_gnt), 32'd1);
    end
    cyc(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    chk("burst_end c_gnt", 32'(c_gnt), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(k < 4 ? mk(0, 0, 0, 0, 0, 1, 0, 100 + k, 0, 0) : idle);
      if (k > 0) begin
        chk($sformatf("burst_rd%0d d_rvalid", k), 32'(d_rvalid), 32'd1);
        chk($sformatf("burst_rd%0d d_rdata", k), d_rdata, 32'hB0000000 + 32'(k - 1));
      end
    end

    // Reset lands mid locked burst just after a granted read.
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 5, 0, 1));
    chk("rstb0 d_gnt", 32'(d_gnt), 32'd1);
    cyc(mk(0, 1, 0, 5, 0, 1, 0, 3, 0, 1));
    chk("rstb1 c_gnt", 32'(c_gnt), 32'd0);
    chk("rstb1 d_gnt", 32'(d_gnt), 32'd1);
    chk("rstb1 d_rdata", d_rdata, 32'hDEADBEEF);
    cyc(mk(1, 1, 0, 5, 0, 1, 1, 3, 32'h77, 1));
    chk("rstb2 c_gnt", 32'(c_gnt), 32'd0);
    chk("rstb2 d_gnt", 32'(d_gnt), 32'd0);
    chk("rstb2 mem_rw", 32'(mem_rw), 32'd0);
    chk("rstb2 d_rvalid", 32'(d_rvalid), 32'd1);
    cyc(mk(0, 1, 0, 5, 0, 1, 0, 3, 0, 1));
    chk("rstb3 d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rstb3 d_rdata", d_rdata, 32'd0);
    chk("rstb3 c_gnt", 32'(c_gnt), 32'd1);
    chk("rstb3 d_gnt", 32'(d_gnt), 32'd0);
    cyc(idle);
    chk("rstb4 c_rdata", c_rdata, 32'hDEADBEEF);

    // Randomized run against the rule-level model.
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    ref_mem = mem;
    m_locked = 0; m_wait = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
    begin
      bit c_pend, d_pend, eg_c, eg_d, forced;
      in_t cur;
      logic        e_rw;
      logic [9:0]  e_addr;
      logic [31:0] e_wd;
      c_pend = 0; d_pend = 0;
      cur = idle;
      for (int k = 0; k < 400; k++) begin
        cur.rst = ($urandom_range(0, 99) < 2);
        if (!c_pend) begin
          cur.c_req = ($urandom_range(0, 99) < 60); cur.c_we = $urandom_range(0, 1);
          cur.c_addr = 10'($urandom_range(0, 15)); cur.c_wdata = $urandom;
        end
        if (!d_pend) begin
          cur.d_req = ($urandom_range(0, 99) < 50); cur.d_we = $urandom_range(0, 1);
          cur.d_addr = 10'($urandom_range(0, 15)); cur.d_wdata = $urandom;
          cur.d_lock = ($urandom_range(0, 99) < 40);
        end
        cyc(cur);
        forced = STARVE_EN && cur.d_req && (m_wait == MAX_WAIT);
        eg_c = !cur.rst && !m_locked && cur.c_req && !forced;
        eg_d = !cur.rst && !eg_c && cur.d_req;
        e_rw = 0; e_addr = 0; e_wd = 0;
        if (eg_c) begin e_rw = cur.c_we; e_addr = cur.c_addr; e_wd = cur.c_wdata; end
        if (eg_d) begin e_rw = cur.d_we; e_addr = cur.d_addr; e_wd = cur.d_wdata; end
        chk($sformatf("rnd%0d c_gnt", k), 32'(c_gnt), 32'(eg_c));
        chk($sformatf("rnd%0d d_gnt", k), 32'(d_gnt), 32'(eg_d));
        chk($sformatf("rnd%0d mem_rw", k), 32'(mem_rw), 32'(e_rw));
        chk($sformatf("rnd%0d mem_addr", k), 32'(mem_addr), 32'(e_addr));
        chk($sformatf("rnd%0d mem_wdata", k), mem_wdata, e_wd);
        chk($sformatf("rnd%0d c_rvalid", k), 32'(c_rvalid), 32'(m_crv));
        chk($sformatf("rnd%0d c_rdata", k), c_rdata, m_crd);
        chk($sformatf("rnd%0d d_rvalid", k), 32'(d_rvalid), 32'(m_drv));
        chk($sformatf("rnd%0d d_rdata", k), d_rdata, m_drd);
        if (cur.rst) begin
          m_locked = 0; m_wait = 0; m_crv = 0; m_drv = 0; m_crd = 0; m_drd = 0;
        end else begin
          m_crv = eg_c && !cur.c_we;
          m_drv = eg_d && !cur.d_we;
          if (m_crv) m_crd = ref_mem[cur.c_addr];
          if (m_drv) m_drd = ref_mem[cur.d_addr];
          if (e_rw) ref_mem[e_addr] = e_wd;
          if (eg_d) m_locked = cur.d_lock;
          else if (!cur.d_req) m_locked = 0;
          m_wait = (cur.d_req && !eg_d) ? m_wait + 1 : 0;
        end
        c_pend = cur.c_req && !eg_c;
        d_pend = cur.d_req && !eg_d;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
